// File: rtl/fp_add_pipe.sv
`default_nettype none
// ============================================================================
// Module   : fp_add_pipe
// Purpose  : 3-stage pipelined FP adder/subtractor, round-to-nearest-even,
//            subnormals flushed to zero, ready/valid with full-pipe stall.
// Revision : 1.0
// ============================================================================
module fp_add_pipe #(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   a,
  input  logic [EXP_W+MAN_W:0]   b,
  input  logic                   sub,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   sum,
  output logic                   ovf,
  output logic                   inexact
);

  localparam int c_W   = 1 + EXP_W + MAN_W;
  localparam int c_AW  = MAN_W + 3;           // hidden, fraction, guard, round
  localparam int c_N   = MAN_W + 4;           // c_AW plus sticky column
  localparam int c_LZW = $clog2(c_N + 1);
  localparam logic [EXP_W-1:0] c_EXP_ONES = '1;

  logic w_en;
  logic r_s1_v, r_s2_v, r_s3_v;

  assign w_en      = !r_s3_v || out_ready;
  assign in_ready  = w_en;
  assign out_valid = r_s3_v;

  // ---------------------------------------------------------------- stage 1
  logic                 w_sa, w_sb;
  logic [EXP_W-1:0]     w_ea, w_eb;
  logic [MAN_W-1:0]     w_fa, w_fb;
  logic                 w_a_nan, w_b_nan, w_a_inf, w_b_inf;
  logic [c_W-2:0]       w_mag_a, w_mag_b;
  logic                 w_a_big;
  logic [c_AW-1:0]      w_ma, w_mb;
  logic                 w_big_s;
  logic [EXP_W-1:0]     w_big_e, w_sml_e, w_diff;
  logic [c_AW-1:0]      w_big_m, w_sml_m, w_sml_sh;
  logic                 w_st;
  logic                 w_nan, w_inf, w_inf_s;

  assign w_sa = a[c_W-1];
  assign w_sb = b[c_W-1] ^ sub;
  assign w_ea = a[c_W-2:MAN_W];
  assign w_eb = b[c_W-2:MAN_W];
  assign w_fa = a[MAN_W-1:0];
  assign w_fb = b[MAN_W-1:0];

  assign w_a_nan = (w_ea == c_EXP_ONES) && (w_fa != '0);
  assign w_b_nan = (w_eb == c_EXP_ONES) && (w_fb != '0);
  assign w_a_inf = (w_ea == c_EXP_ONES) && (w_fa == '0);
  assign w_b_inf = (w_eb == c_EXP_ONES) && (w_fb == '0);

  assign w_nan   = w_a_nan || w_b_nan || (w_a_inf && w_b_inf && (w_sa != w_sb));
  assign w_inf   = w_a_inf || w_b_inf;
  assign w_inf_s = w_a_inf ? w_sa : w_sb;

  // Zero exponent means zero here: subnormal fractions are discarded.
  assign w_mag_a = (w_ea == '0) ? '0 : a[c_W-2:0];
  assign w_mag_b = (w_eb == '0) ? '0 : b[c_W-2:0];
  assign w_a_big = (w_mag_a >= w_mag_b);
  assign w_ma    = (w_ea == '0) ? '0 : {1'b1, w_fa, 2'b00};
  assign w_mb    = (w_eb == '0) ? '0 : {1'b1, w_fb, 2'b00};

  always_comb begin
    if (w_a_big) begin
      w_big_s = w_sa;
      w_big_e = w_ea;
      w_big_m = w_ma;
      w_sml_e = w_eb;
      w_sml_m = w_mb;
    end else begin
      w_big_s = w_sb;
      w_big_e = w_eb;
      w_big_m = w_mb;
      w_sml_e = w_ea;
      w_sml_m = w_ma;
    end
  end

  assign w_diff = w_big_e - w_sml_e;

  always_comb begin
    if (32'(w_diff) >= 32'(c_AW)) begin
      w_sml_sh = '0;
      w_st     = |w_sml_m;
    end else begin
      w_sml_sh = w_sml_m >> w_diff;
      w_st     = |(w_sml_m & ~({c_AW{1'b1}} << w_diff));
    end
  end

  logic                 r_s1_nan, r_s1_inf, r_s1_inf_s, r_s1_s, r_s1_sub, r_s1_st;
  logic [EXP_W-1:0]     r_s1_e;
  logic [c_AW-1:0]      r_s1_mb, r_s1_ms;

  always_ff @(posedge clk) begin
    if (w_en) begin
      r_s1_nan   <= w_nan;
      r_s1_inf   <= w_inf;
      r_s1_inf_s <= w_inf_s;
      r_s1_s     <= w_big_s;
      r_s1_sub   <= (w_sa != w_sb);
      r_s1_e     <= w_big_e;
      r_s1_mb    <= w_big_m;
      r_s1_ms    <= w_sml_sh;
      r_s1_st    <= w_st;
    end
  end

  // ---------------------------------------------------------------- stage 2
  // Sticky rides as an extra LSB so a borrow from it leaves the upper bits
  // equal to the exact truncated difference.
  logic [c_N-1:0]       w_opb, w_ops;
  logic [c_N:0]         w_res;
  logic [c_LZW-1:0]     w_lzc;
  logic [c_N-1:0]       w_n_m;
  logic [EXP_W-1:0]     w_n_e;
  logic                 w_n_flush;

  assign w_opb = {r_s1_mb, 1'b0};
  assign w_ops = {r_s1_ms, r_s1_st};
  assign w_res = r_s1_sub ? ({1'b0, w_opb} - {1'b0, w_ops})
                          : ({1'b0, w_opb} + {1'b0, w_ops});

  always_comb begin
    w_lzc = '0;
    for (int i = 0; i < c_N; i++) begin
      if (w_res[i]) w_lzc = c_LZW'(c_N - 1 - i);
    end
  end

  // A zero hidden bit in w_n_m marks "no normal result" (cancel or flush).
  always_comb begin
    w_n_flush = 1'b0;
    w_n_e     = r_s1_e;
    w_n_m     = '0;
    if (w_res[c_N]) begin
      w_n_m = {w_res[c_N:2], w_res[1] | w_res[0]};
      w_n_e = r_s1_e + EXP_W'(1);
    end else if (w_res[c_N-1:0] == '0) begin
      w_n_m = '0;
    end else if (32'(r_s1_e) <= 32'(w_lzc)) begin
      w_n_flush = 1'b1;
    end else begin
      w_n_m = w_res[c_N-1:0] << w_lzc;
      w_n_e = r_s1_e - EXP_W'(w_lzc);
    end
  end

  logic                 r_s2_nan, r_s2_inf, r_s2_inf_s, r_s2_s, r_s2_flush;
  logic [EXP_W-1:0]     r_s2_e;
  logic [c_N-1:0]       r_s2_m;

  always_ff @(posedge clk) begin
    if (w_en) begin
      r_s2_nan   <= r_s1_nan;
      r_s2_inf   <= r_s1_inf;
      r_s2_inf_s <= r_s1_inf_s;
      r_s2_s     <= r_s1_s;
      r_s2_flush <= w_n_flush;
      r_s2_e     <= w_n_e;
      r_s2_m     <= w_n_m;
    end
  end

  // ---------------------------------------------------------------- stage 3
  logic                 w_lsb, w_g, w_rs, w_rup;
  logic [MAN_W:0]       w_rm;
  logic [EXP_W:0]       w_re;
  logic [c_W-1:0]       w_o_sum;
  logic                 w_o_ovf, w_o_inx;

  assign w_lsb = r_s2_m[3];
  assign w_g   = r_s2_m[2];
  assign w_rs  = r_s2_m[1] | r_s2_m[0];
  assign w_rup = w_g & (w_rs | w_lsb);
  // Hidden bit is implicitly 1 here, so a fraction carry means mantissa 2.0.
  assign w_rm  = {1'b0, r_s2_m[c_N-2:3]} + (MAN_W+1)'(w_rup);
  assign w_re  = {1'b0, r_s2_e} + (EXP_W+1)'(w_rm[MAN_W]);

  always_comb begin
    w_o_sum = {r_s2_s, w_re[EXP_W-1:0], w_rm[MAN_W-1:0]};
    w_o_ovf = 1'b0;
    w_o_inx = w_g | w_rs;
    if (r_s2_nan) begin
      w_o_sum = {1'b0, c_EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};
      w_o_inx = 1'b0;
    end else if (r_s2_inf) begin
      w_o_sum = {r_s2_inf_s, c_EXP_ONES, {MAN_W{1'b0}}};
      w_o_inx = 1'b0;
    end else if (r_s2_flush) begin
      w_o_sum = {r_s2_s, {(c_W-1){1'b0}}};
      w_o_inx = 1'b1;
    end else if (!r_s2_m[c_N-1]) begin
      w_o_sum = '0;
      w_o_inx = 1'b0;
    end else if (w_re >= {1'b0, c_EXP_ONES}) begin
      w_o_sum = {r_s2_s, c_EXP_ONES, {MAN_W{1'b0}}};
      w_o_ovf = 1'b1;
      w_o_inx = 1'b1;
    end
  end

  logic [c_W-1:0] r_sum;
  logic           r_ovf, r_inexact;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_v    <= 1'b0;
      r_s2_v    <= 1'b0;
      r_s3_v    <= 1'b0;
      r_sum     <= '0;
      r_ovf     <= 1'b0;
      r_inexact <= 1'b0;
    end else if (w_en) begin
      r_s1_v <= in_valid;
      r_s2_v <= r_s1_v;
      r_s3_v <= r_s2_v;
      if (r_s2_v) begin
        r_sum     <= w_o_sum;
        r_ovf     <= w_o_ovf;
        r_inexact <= w_o_inx;
      end
    end
  end

  assign sum     = r_sum;
  assign ovf     = r_ovf;
  assign inexact = r_inexact;

endmodule
`default_nettype wire

// File: tb/tb_fp_add_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp_add_pipe
// Purpose  : Directed self-checking bench for fp_add_pipe (binary16 defaults).
// Revision : 1.0
// ============================================================================
module tb_fp_add_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        sub = 1'b0;
  logic        out_ready = 1'b1;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        in_ready, out_valid, ovf, inexact;
  logic [15:0] sum;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        s;
    logic [15:0] e;
    logic        ov;
    logic        ix;
  } vec_t;

  always #5 clk = ~clk;

  fp_add_pipe dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .ovf       (ovf),
    .inexact   (inexact)
  );

  // One operation into an idle pipe; returns the result and its latency
  // (-1 if nothing appears), then lets the result drain.
  task automatic do_op(input logic [15:0] ia, input logic [15:0] ib, input logic isub,
                       output logic [15:0] osum, output logic oovf, output logic oinx,
                       output int lat);
    @(negedge clk);
    a = ia; b = ib; sub = isub; in_valid = 1'b1; out_ready = 1'b1;
    lat = -1; osum = '0; oovf = 1'b0; oinx = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      if (out_valid) begin
        lat = c; osum = sum; oovf = ovf; oinx = inexact;
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    total++; if (sum !== 16'h0000) begin bad++; $display("FAIL reset_sum: got %h want 0000", sum); end
    total++; if (ovf !== 1'b0) begin bad++; $display("FAIL reset_ovf: got %b want 0", ovf); end
    total++; if (inexact !== 1'b0) begin bad++; $display("FAIL reset_inexact: got %b want 0", inexact); end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL post_reset_out_valid: got %b want 0", out_valid); end
  endtask

  task automatic test_basic();
    vec_t v [6];
    logic [15:0] rs; logic ro, ri; int lat;
    v[0] = '{16'h3C00, 16'h3C00, 1'b0, 16'h4000, 1'b0, 1'b0};
    v[1] = '{16'h4000, 16'h3C00, 1'b1, 16'h3C00, 1'b0, 1'b0};
    v[2] = '{16'h3C00, 16'hBC00, 1'b0, 16'h0000, 1'b0, 1'b0};
    v[3] = '{16'h3C00, 16'h3C00, 1'b1, 16'h0000, 1'b0, 1'b0};
    v[4] = '{16'h4000, 16'h4200, 1'b0, 16'h4500, 1'b0, 1'b0};
    v[5] = '{16'hC000, 16'h3C00, 1'b0, 16'hBC00, 1'b0, 1'b0};
    foreach (v[k]) begin
      do_op(v[k].a, v[k].b, v[k].s, rs, ro, ri, lat);
      total++; if (lat != 3) begin bad++; $display("FAIL basic[%0d] latency: got %0d want 3", k, lat); end
      total++; if (rs !== v[k].e) begin bad++; $display("FAIL basic[%0d] sum: got %h want %h", k, rs, v[k].e); end
      total++; if (ro !== v[k].ov) begin bad++; $display("FAIL basic[%0d] ovf: got %b want %b", k, ro, v[k].ov); end
      total++; if (ri !== v[k].ix) begin bad++; $display("FAIL basic[%0d] inexact: got %b want %b", k, ri, v[k].ix); end
    end
  endtask

  task automatic test_rounding();
    vec_t v [5];
    logic [15:0] rs; logic ro, ri; int lat;
    v[0] = '{16'h3C00, 16'h1000, 1'b0, 16'h3C00, 1'b0, 1'b1};  // tie, even stays
    v[1] = '{16'h3C00, 16'h1200, 1'b0, 16'h3C01, 1'b0, 1'b1};  // above half
    v[2] = '{16'h3C01, 16'h1000, 1'b0, 16'h3C02, 1'b0, 1'b1};  // tie, odd rounds up
    v[3] = '{16'h3C00, 16'h0400, 1'b0, 16'h3C00, 1'b0, 1'b1};  // shift past all bits
    v[4] = '{16'h3C00, 16'h0400, 1'b1, 16'h3C00, 1'b0, 1'b1};  // round carry renormalises
    foreach (v[k]) begin
      do_op(v[k].a, v[k].b, v[k].s, rs, ro, ri, lat);
      total++; if (lat != 3) begin bad++; $display("FAIL round[%0d] latency: got %0d want 3", k, lat); end
      total++; if (rs !== v[k].e) begin bad++; $display("FAIL round[%0d] sum: got %h want %h", k, rs, v[k].e); end
      total++; if (ro !== v[k].ov) begin bad++; $display("FAIL round[%0d] ovf: got %b want %b", k, ro, v[k].ov); end
      total++; if (ri !== v[k].ix) begin bad++; $display("FAIL round[%0d] inexact: got %b want %b", k, ri, v[k].ix); end
    end
  endtask

  task automatic test_special();
    vec_t v [8];
    logic [15:0] rs; logic ro, ri; int lat;
    v[0] = '{16'h7BFF, 16'h7BFF, 1'b0, 16'h7C00, 1'b1, 1'b1};  // overflow
    v[1] = '{16'h7C00, 16'hFC00, 1'b0, 16'h7E00, 1'b0, 1'b0};  // inf - inf
    v[2] = '{16'h7C00, 16'h7C00, 1'b1, 16'h7E00, 1'b0, 1'b0};
    v[3] = '{16'h7C00, 16'h3C00, 1'b0, 16'h7C00, 1'b0, 1'b0};
    v[4] = '{16'h3C00, 16'h7C00, 1'b1, 16'hFC00, 1'b0, 1'b0};
    v[5] = '{16'h7C01, 16'h3C00, 1'b0, 16'h7E00, 1'b0, 1'b0};  // NaN in
    v[6] = '{16'h0401, 16'h0400, 1'b1, 16'h0000, 1'b0, 1'b1};  // underflow flush
    v[7] = '{16'h0001, 16'h3C00, 1'b0, 16'h3C00, 1'b0, 1'b0};  // subnormal input
    foreach (v[k]) begin
      do_op(v[k].a, v[k].b, v[k].s, rs, ro, ri, lat);
      total++; if (lat != 3) begin bad++; $display("FAIL special[%0d] latency: got %0d want 3", k, lat); end
      total++; if (rs !== v[k].e) begin bad++; $display("FAIL special[%0d] sum: got %h want %h", k, rs, v[k].e); end
      total++; if (ro !== v[k].ov) begin bad++; $display("FAIL special[%0d] ovf: got %b want %b", k, ro, v[k].ov); end
      total++; if (ri !== v[k].ix) begin bad++; $display("FAIL special[%0d] inexact: got %b want %b", k, ri, v[k].ix); end
    end
  endtask

  task automatic test_back_to_back();
    vec_t v [5];
    int nin = 0;
    int nout = 0;
    logic stall_seen = 1'b0;
    logic holding = 1'b0;
    logic accepted;
    logic [15:0] held = '0;
    v[0] = '{16'h3C00, 16'h3C00, 1'b0, 16'h4000, 1'b0, 1'b0};
    v[1] = '{16'h4000, 16'h3C00, 1'b1, 16'h3C00, 1'b0, 1'b0};
    v[2] = '{16'h3C00, 16'h1200, 1'b0, 16'h3C01, 1'b0, 1'b1};
    v[3] = '{16'h7BFF, 16'h7BFF, 1'b0, 16'h7C00, 1'b1, 1'b1};
    v[4] = '{16'h3C00, 16'hBC00, 1'b0, 16'h0000, 1'b0, 1'b0};
    for (int cyc = 0; cyc < 40 && nout < 5; cyc++) begin
      @(negedge clk);
      out_ready = !(cyc >= 4 && cyc <= 7);
      if (nin < 5) begin
        in_valid = 1'b1; a = v[nin].a; b = v[nin].b; sub = v[nin].s;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      total++; if (in_ready !== (!out_valid || out_ready)) begin bad++; $display("FAIL b2b in_ready cyc%0d: got %b want %b", cyc, in_ready, !out_valid || out_ready); end
      if (!in_ready) stall_seen = 1'b1;
      if (out_valid && !out_ready) begin
        if (holding) begin
          total++; if (sum !== held) begin bad++; $display("FAIL b2b hold cyc%0d: got %h want %h", cyc, sum, held); end
        end
        held = sum; holding = 1'b1;
      end else begin
        holding = 1'b0;
      end
      if (out_valid && out_ready) begin
        total++; if (sum !== v[nout].e) begin bad++; $display("FAIL b2b[%0d] sum: got %h want %h", nout, sum, v[nout].e); end
        total++; if (ovf !== v[nout].ov) begin bad++; $display("FAIL b2b[%0d] ovf: got %b want %b", nout, ovf, v[nout].ov); end
        total++; if (inexact !== v[nout].ix) begin bad++; $display("FAIL b2b[%0d] inexact: got %b want %b", nout, inexact, v[nout].ix); end
        nout++;
      end
      accepted = in_valid && in_ready;
      @(posedge clk);
      if (accepted) nin++;
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    total++; if (nout != 5) begin bad++; $display("FAIL b2b count: got %0d want 5", nout); end
    total++; if (stall_seen !== 1'b1) begin bad++; $display("FAIL b2b stall: in_ready low seen %b want 1", stall_seen); end
    repeat (4) @(posedge clk);
  endtask

  task automatic test_reset_inflight();
    int seen = 0;
    int lat;
    logic [15:0] rs; logic ro, ri;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      in_valid = 1'b1; a = 16'h3C00; b = 16'h3C00; sub = 1'b0; out_ready = 1'b1;
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0;
    #1;
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL inflight setup out_valid: got %b want 1", out_valid); end
    #1 rst_n = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL inflight async out_valid: got %b want 0", out_valid); end
    total++; if (sum !== 16'h0000) begin bad++; $display("FAIL inflight async sum: got %h want 0000", sum); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL inflight in_ready: got %b want 1", in_ready); end
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    total++; if (seen != 0) begin bad++; $display("FAIL inflight stale results: got %0d want 0", seen); end
    do_op(16'h4000, 16'h4000, 1'b0, rs, ro, ri, lat);
    total++; if (lat != 3) begin bad++; $display("FAIL inflight new latency: got %0d want 3", lat); end
    total++; if (rs !== 16'h4400) begin bad++; $display("FAIL inflight new sum: got %h want 4400", rs); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_rounding();
    test_special();
    test_back_to_back();
    test_reset_inflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
`default_nettype wire
